// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers, with fixed multi-cycle latency.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module mdu_iterative #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               load;

    logic [2*WIDTH-1:0] prod_s, prod_u, mul_res, div_res;

    function automatic logic is_mul_op(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // Returns {remainder, quotient}; divide-by-zero and overflow give fixed results.
    function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (x == MOST_NEG && y == '1) begin
            q = x;
            r = '0;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end
        return {r, q};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] x,
                                                        input logic [WIDTH-1:0] y);
        if (y == '0)
            return {x, {WIDTH{1'b1}}};
        return {x % y, x / y};
    endfunction

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    always_comb begin
        prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        div_res = (op_q == OP_DIV) ? div_signed(a_q, b_q) : div_unsigned(a_q, b_q);
        case (op_q)
            OP_MULT:  mul_res = prod_s;
`ifdef MDU_MADD_EN
            OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
            OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
`endif
            default:  mul_res = prod_u;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul_op(op)) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        load    = 1'b1;
                    end else if (is_div_op(op)) begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(DIV_LAT - 1);
                        load    = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = (state_q == S_MUL) ? mul_res : div_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = busy_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand capture needs no reset: only read while the FSM is busy.
    always_ff @(posedge clk) begin
        if (load) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
